fc_seq_layer: RTL
=================

Name: fc_seq_layer

Overview:
- Parametrised, time-multiplexed fully-connected layer engine: one signed fixed-point MAC per cycle, streaming inputs, weights and biases from the shared FC memory over a single-port read/write interface.
- Writes each output neuron back to memory, with optional ReLU.
- Successor to the fully-parallel FC stage: one instance per layer (120->84, 84->10), sequenced by the FC top via enable/finished.

Parameters:
NUM_IN, 120, input nodes per neuron (>=1)
NUM_OUT, 84, output neurons (>=1)
DATA_W, 16, signed data/weight/bias width
FRAC_W, 8, fractional bits of all operands (1..DATA_W-1)
ADDR_W, 14, memory address width
IN_BASE, 0, address of input[0]
W_BASE, 120, address of weight[0][0]; weight[o][i] at W_BASE+o*NUM_IN+i
B_BASE, 10200, address of bias[0]; bias[o] at B_BASE+o
OUT_BASE, 10284, address of output[0]; output[o] at OUT_BASE+o
RELU, 1, 1 = clamp negative results to 0

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  level; start request and abort control
finished  out  1  layer complete; held until enable drops
busy  out  1  high in every state except IDLE and DONE
mem_addr  out  ADDR_W  shared read/write address
mem_rd_en  out  1  read strobe; mem_rdata valid exactly one cycle later
mem_rdata  in  DATA_W  read data
mem_wr_en  out  1  write strobe
mem_wdata  out  DATA_W  write data

Behaviour:
- Reset: async, rst_n low -> state IDLE, all outputs 0, counters and accumulator 0. Reset mid-operation discards all progress; no write issued.
- States:
  - IDLE: enable high at a clock edge -> LOAD_IN.
  - LOAD_IN: issue reads IN_BASE..IN_BASE+NUM_IN-1 on consecutive cycles (mem_rd_en=1). Capture each mem_rdata into local input buffer inputs[0..NUM_IN-1] the following cycle. NUM_IN+1 cycles total, then MAC with o=0.
  - MAC (per neuron o): cycle 0 issues read B_BASE+o. Cycles 1..NUM_IN issue W_BASE+o*NUM_IN+(k-1). Bias captured at cycle 1 into acc as sign-extended bias<<<FRAC_W. Each weight captured the next cycle and acc += weight*inputs[k]. NUM_IN+2 cycles, then WRITE.
  - WRITE: single cycle; mem_wr_en=1, mem_addr=OUT_BASE+o, mem_wdata=result. If o==NUM_OUT-1 -> DONE, else o++ -> MAC.
  - DONE: finished=1; stays until enable low -> IDLE (finished drops same edge).
- Latency: finished rises (NUM_IN+1)+NUM_OUT*(NUM_IN+3)+1 edges after the edge that sampled enable high in IDLE.
- Abort: enable low in LOAD_IN/MAC/WRITE -> IDLE next edge. No further reads or writes; finished stays 0.
- mem_rd_en and mem_wr_en are never high in the same cycle. mem_addr is 0 when both are low.
- Arithmetic:
  - Products are full 2*DATA_W signed.
  - Accumulator ACC_W = 2*DATA_W + clog2(NUM_IN) + 1; no internal overflow possible.
  - Result: (acc + (1<<(FRAC_W-1))) >>> FRAC_W (round half up), saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Then, if RELU=1, negative -> 0.
- enable held high after DONE does not restart; a new run needs enable low for >=1 edge.

Test Plan:
- NUM_IN=3, NUM_OUT=2, FRAC_W=8, RELU=1. Inputs 0x0100, 0x0200, 0xFF00; weights row0 0x0080 x3, row1 0x0100 x3; biases 0x0040, 0xFD00 -> mem[OUT_BASE]=0x0140, mem[OUT_BASE+1]=0x0000; finished rises exactly 17 edges after start.
- Same vectors, RELU=0 -> output[1]=0xFF00.
- Saturation: inputs and weights all 0x7F00, bias 0x7FFF -> 0x7FFF. Inputs 0x7F00, weights 0x8100 -> 0x8000 with RELU=0, 0x0000 with RELU=1.
- Rounding: input 0x0001, weight 0x0080, bias 0 -> acc=0x80 -> output 0x0001. Weight 0x007F -> output 0x0000.
- Abort/reset: drop enable during neuron 0 MAC -> no mem_wr_en ever, busy=0 next edge, finished=0. Assert rst_n low mid-LOAD_IN -> all outputs 0 immediately. Re-run completes normally.
- Handshake: hold enable after DONE for 10 cycles -> finished stays 1, no new reads. Drop enable -> finished 0 next edge. Re-raise -> full second run gives identical writes.

Source files
------------

// File: rtl/fc_seq_layer.sv
// Time-multiplexed fully-connected layer: one signed fixed-point MAC per cycle.
// Inputs, weights and biases come from a shared single-port memory; each neuron result is written back to it.
module fc_seq_layer #(
    parameter int NUM_IN   = 120,
    parameter int NUM_OUT  = 84,
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 8,
    parameter int ADDR_W   = 14,
    parameter int IN_BASE  = 0,
    parameter int W_BASE   = 120,
    parameter int B_BASE   = 10200,
    parameter int OUT_BASE = 10284,
    parameter int RELU     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              finished,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata
);

    localparam int ACC_W  = 2*DATA_W + $clog2(NUM_IN) + 1;
    localparam int CNT_W  = $clog2(NUM_IN + 2) + 1;
    localparam int OUT_CW = $clog2(NUM_OUT) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_MAC   = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CNT_W-1:0]  LAST_LOAD = CNT_W'(NUM_IN);
    localparam logic [CNT_W-1:0]  LAST_MAC  = CNT_W'(NUM_IN + 1);
    localparam logic [OUT_CW-1:0] LAST_OUT  = OUT_CW'(NUM_OUT - 1);

    localparam logic signed [ACC_W:0] SAT_MAX  = (ACC_W+1)'((2**(DATA_W-1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN  = (ACC_W+1)'(-(2**(DATA_W-1)));
    localparam logic signed [ACC_W:0] RND_HALF = (ACC_W+1)'(2**(FRAC_W-1));

    logic [2:0]                state;
    logic [CNT_W-1:0]          cnt;
    logic [OUT_CW-1:0]         o_idx;
    logic signed [ACC_W-1:0]   acc;
    logic signed [DATA_W-1:0]  inputs [NUM_IN];

    logic signed [DATA_W-1:0]   sel_in;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    bias_ext;
    logic signed [ACC_W:0]      rnd;
    logic signed [ACC_W:0]      shr;
    logic [DATA_W-1:0]          result;

    // In MAC cycle c (c >= 2) the weight read in cycle c-1 pairs with inputs[c-2].
    always_comb begin
        sel_in = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (cnt == CNT_W'(i + 2)) sel_in = inputs[i];
        end
    end

    assign prod     = $signed(mem_rdata) * sel_in;
    assign bias_ext = ACC_W'($signed(mem_rdata)) <<< FRAC_W;

    // Round half up, then saturate to the data range, then optional ReLU.
    always_comb begin
        rnd    = $signed({acc[ACC_W-1], acc}) + RND_HALF;
        shr    = rnd >>> FRAC_W;
        result = shr[DATA_W-1:0];
        if (shr > SAT_MAX)      result = SAT_MAX[DATA_W-1:0];
        else if (shr < SAT_MIN) result = SAT_MIN[DATA_W-1:0];
        if (RELU != 0 && result[DATA_W-1]) result = '0;
    end

    assign busy = (state != S_IDLE) && (state != S_DONE);

    // Strobes are gated by enable so an abort stops memory traffic in the same cycle.
    always_comb begin
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (enable) begin
            case (state)
                S_LOAD: begin
                    if (cnt < LAST_LOAD) begin
                        mem_rd_en = 1'b1;
                        mem_addr  = ADDR_W'(IN_BASE + int'(cnt));
                    end
                end
                S_MAC: begin
                    if (cnt == '0) begin
                        mem_rd_en = 1'b1;
                        mem_addr  = ADDR_W'(B_BASE + int'(o_idx));
                    end else if (cnt <= LAST_LOAD) begin
                        mem_rd_en = 1'b1;
                        mem_addr  = ADDR_W'(W_BASE + int'(o_idx) * NUM_IN + int'(cnt) - 1);
                    end
                end
                S_WRITE: begin
                    mem_wr_en = 1'b1;
                    mem_addr  = ADDR_W'(OUT_BASE + int'(o_idx));
                    mem_wdata = result;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            o_idx    <= '0;
            acc      <= '0;
            finished <= 1'b0;
            for (int i = 0; i < NUM_IN; i++) inputs[i] <= '0;
        end else begin
            finished <= (state == S_DONE) && enable;
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state <= S_LOAD;
                        cnt   <= '0;
                        o_idx <= '0;
                    end
                end
                S_LOAD: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else begin
                        for (int i = 0; i < NUM_IN; i++) begin
                            if (cnt == CNT_W'(i + 1)) inputs[i] <= $signed(mem_rdata);
                        end
                        if (cnt == LAST_LOAD) begin
                            state <= S_MAC;
                            cnt   <= '0;
                            o_idx <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_MAC: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else begin
                        if (cnt == CNT_W'(1))      acc <= bias_ext;
                        else if (cnt >= CNT_W'(2)) acc <= acc + ACC_W'(prod);
                        if (cnt == LAST_MAC) begin
                            state <= S_WRITE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_WRITE: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else if (o_idx == LAST_OUT) begin
                        state <= S_DONE;
                    end else begin
                        o_idx <= o_idx + OUT_CW'(1);
                        state <= S_MAC;
                        cnt   <= '0;
                    end
                end
                S_DONE: begin
                    if (!enable) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
